// File: rtl/key_press_detector_if.sv
// key_press_detector_if: raw key levels in, debounced pulses and held levels out
interface key_press_detector_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] held;
  modport master (output key_sync, input press_pulse, release_pulse, held);
  modport slave (input key_sync, output press_pulse, release_pulse, held);
endinterface

// File: rtl/key_press_detector.sv
// key_press_detector: per-lane debouncer emitting press/release pulses and a held level
module key_press_detector #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  key_press_detector_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  logic [NUM_KEYS-1:0] k, press_v, release_v, held_v;
  assign k = bus.key_sync ^ {NUM_KEYS{ACTIVE_LOW}};
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic press_q, press_d, release_q, release_d, held_q, held_d;
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: if (k[i]) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
        PRESS_WAIT: if (!k[i]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
        PRESSED: if (!k[i]) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
        RELEASE_WAIT: if (k[i]) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      endcase
      held_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        held_q    <= held_d;
      end
    end
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;
    assign held_v[i]    = held_q;
  end
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.held          = held_v;
endmodule

// File: tb/tb_key_press_detector.sv
// tb_key_press_detector: vector table plus scoreboard for active-low and active-high instances
module tb_key_press_detector;
  typedef struct {
    logic       rst;
    logic [3:0] ks;
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] eh;
  } vec_t;
  typedef struct {
    bit         sel;
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] eh;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  string phase = "init";
  vec_t vecs[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  key_press_detector_if #(.NUM_KEYS(4)) bus_a ();
  key_press_detector_if #(.NUM_KEYS(4)) bus_b ();
  key_press_detector #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  key_press_detector #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  task automatic add(input logic r, input logic [3:0] ks, ep, er, eh, input int n);
    for (int j = 0; j < n; j++) vecs.push_back('{r, ks, ep, er, eh});
  endtask
  task automatic check(input string name, input logic [3:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cycle %0d: got %b expected %b", phase, name, cyc, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] ka, kb, input bit sel,
                      input logic [3:0] ep, er, eh);
    exp_t e;
    logic [3:0] ap, ar, ah;
    @(negedge clk);
    reset = r;
    bus_a.key_sync = ka;
    bus_b.key_sync = kb;
    sb.push_back('{sel, ep, er, eh});
    @(posedge clk);
    #1;
    cyc++;
    e  = sb.pop_front();
    ap = e.sel ? bus_b.press_pulse : bus_a.press_pulse;
    ar = e.sel ? bus_b.release_pulse : bus_a.release_pulse;
    ah = e.sel ? bus_b.held : bus_a.held;
    check("press", ap, e.ep);
    check("release", ar, e.er);
    check("held", ah, e.eh);
    check("exclusive", ap & ar, 4'b0000);
  endtask
  initial begin
    bus_a.key_sync = 4'b1111;
    bus_b.key_sync = 4'b0000;
    // reset, then clean press on lane 0
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
    add(0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 3);
    add(0, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 1);
    add(0, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 6);
    // lane 1 bounce never qualifies
    add(0, 4'b1100, 4'b0000, 4'b0000, 4'b0001, 3);
    add(0, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 1);
    add(0, 4'b1100, 4'b0000, 4'b0000, 4'b0001, 3);
    add(0, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 1);
    // lane 0 release with a one-sample bounce
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2);
    add(0, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 3);
    add(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
    // lanes 1 and 3 together
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 3);
    add(0, 4'b0101, 4'b1010, 4'b0000, 4'b1010, 1);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1010, 2);
    // release lane 1, then reset while lane 3 is held
    add(0, 4'b0111, 4'b0000, 4'b0000, 4'b1010, 3);
    add(0, 4'b0111, 4'b0000, 4'b0010, 4'b1000, 1);
    add(1, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1);
    add(0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 3);
    add(0, 4'b0111, 4'b1000, 4'b0000, 4'b1000, 1);
    add(0, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 1);
    phase = "table";
    foreach (vecs[n]) step(vecs[n].rst, vecs[n].ks, 4'b0000, 1'b0, vecs[n].ep, vecs[n].er, vecs[n].eh);
    phase = "reset_mid_release";
    step(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1000);
    step(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1000);
    step(1, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    phase = "reset_mid_press";
    for (int j = 0; j < 3; j++) step(0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    step(1, 4'b1011, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int j = 0; j < 3; j++) step(0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1011, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0100);
    step(0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100);
    phase = "active_high";
    for (int j = 0; j < 3; j++) step(0, 4'b1011, 4'b0100, 1, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1011, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0100);
    step(0, 4'b1011, 4'b0100, 1, 4'b0000, 4'b0000, 4'b0100);
    for (int j = 0; j < 3; j++) step(0, 4'b1011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100);
    step(0, 4'b1011, 4'b0000, 1, 4'b0000, 4'b0100, 4'b0000);
    step(0, 4'b1011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_press_detector.md
Name: key_press_detector

Overview:
- Per-lane debouncer and edge detector that consumes the 2-FF synchronized DE1-SoC KEY signals.
- Qualifies each lane as pressed or released only after a stable-level window.
- Emits one-cycle press and release pulses plus a debounced held level for the rhythm game's hit-judgement logic.
- All lanes are independent and processed in parallel. The block is purely synchronous to clk.

Parameters:
- NUM_KEYS, 4, number of independent key lanes.
- DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a level change; legal range 2..65535.
- ACTIVE_LOW, 1, 1 = key_sync lane reads 0 when pressed (DE1-SoC KEY); 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- key_sync  input  NUM_KEYS  synchronized raw key levels, one bit per lane.
- press_pulse  output  NUM_KEYS  one-cycle pulse per lane on an accepted press.
- release_pulse  output  NUM_KEYS  one-cycle pulse per lane on an accepted release.
- held  output  NUM_KEYS  debounced pressed level per lane.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Active level: k[i] = key_sync[i] XOR ACTIVE_LOW, so k=1 means pressed. No further input registering; the upstream synchronizer already provides that.
- Per-lane resources: one state machine, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, and a counter cnt of width $clog2(DEBOUNCE_CYCLES).
- All outputs are registered. press_pulse and release_pulse default to 0 every cycle unless set by a transition below.
- IDLE: held=0.
  - k=1 -> PRESS_WAIT, cnt<=1.
  - Otherwise stay.
- PRESS_WAIT: held=0.
  - k=0 -> IDLE, cnt<=0, no pulse.
  - k=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse[i]<=1; held[i]<=1.
  - Otherwise cnt<=cnt+1.
- PRESSED: held=1.
  - k=0 -> RELEASE_WAIT, cnt<=1.
  - Otherwise stay.
- RELEASE_WAIT: held stays 1.
  - k=1 -> PRESSED, cnt<=0, no pulse (treated as bounce).
  - k=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; release_pulse[i]<=1; held[i]<=0.
  - Otherwise cnt<=cnt+1.
- Latency:
  - k must be sampled 1 on DEBOUNCE_CYCLES consecutive rising edges.
  - press_pulse and the held rise are visible in the cycle after the last of those edges.
  - Release timing is symmetric.
- Pulse width: exactly one clk cycle per accepted edge. A continuous hold never produces a second press_pulse.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES samples produces no pulse and no held change.
- Simultaneous lanes:
  - Any subset of lanes may pulse in the same cycle; there is no arbitration or priority.
  - press_pulse[i] and release_pulse[i] are never high together for the same lane.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps; it is only meaningful in the WAIT states.
- Reset (sampled on a clk edge, overriding all other behaviour):
  - All lanes go to IDLE, cnt=0.
  - press_pulse=0, release_pulse=0, held=0 from the cycle after the reset edge.
- Reset mid-press:
  - No release_pulse is generated.
  - A key still held after reset deasserts is re-qualified from IDLE and yields a fresh press_pulse DEBOUNCE_CYCLES edges later.
- Reset mid-wait: any partial count is discarded.

Test Plan (NUM_KEYS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1; idle key_sync=4'b1111):
1. Reset then clean press: hold reset 2 cycles, then drive key_sync[0]=0 for 10 cycles -> outputs all 0 during and after reset; press_pulse=4'b0001 for exactly 1 cycle starting 4 edges after key_sync[0] falls; held[0]=1 from that cycle on.
2. Bounce rejection: on lane 1, drive 0 for 3 cycles, 1 for 1 cycle, 0 for 3 cycles, then 1 -> press_pulse[1] and held[1] stay 0 throughout.
3. Clean release with release bounce: lane 0 held, then key_sync[0]=1 for 2 cycles, 0 for 1 cycle, 1 for 6 cycles -> no pulse during the bounce; release_pulse=4'b0001 for 1 cycle, 4 edges after the final rise; held[0] falls in that same cycle.
4. Simultaneous lanes: key_sync 4'b1111 -> 4'b0101 in one cycle -> press_pulse=4'b1010 for 1 cycle; held=4'b1010; lanes 0 and 2 stay 0.
5. Reset mid-hold: with held=4'b1000, assert reset 1 cycle while key_sync[3] stays 0 -> held=0 and release_pulse=0 after reset; press_pulse[3] pulses again 4 edges after reset deasserts.
6. ACTIVE_LOW=0 instance: key_sync[2] 0->1 stable 4 edges -> press_pulse=4'b0100; 1->0 stable 4 edges -> release_pulse=4'b0100.
